// File: rtl/serial_word_assembler_if.sv
// Bus between the serial feeder and serial_word_assembler.
//   master modport: drives serial_in/bit_valid/frame_start, observes the word side.
//   slave  modport: the assembler; drives data_out/load/busy/bit_count
//                   (and parity_err when PARITY_CHECK_EN is defined).
//   WIDTH must match the assembler's WIDTH.
// Build option: PARITY_CHECK_EN adds the parity_err signal to both modports.
interface serial_word_assembler_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic             serial_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] data_out;
    logic             load;
    logic             busy;
    logic [CntW-1:0]  bit_count;
`ifdef PARITY_CHECK_EN
    logic             parity_err;

    modport master (
        output serial_in, bit_valid, frame_start,
        input  data_out, load, busy, bit_count, parity_err
    );
    modport slave (
        input  serial_in, bit_valid, frame_start,
        output data_out, load, busy, bit_count, parity_err
    );
`else
    modport master (
        output serial_in, bit_valid, frame_start,
        input  data_out, load, busy, bit_count
    );
    modport slave (
        input  serial_in, bit_valid, frame_start,
        output data_out, load, busy, bit_count
    );
`endif
endinterface

// File: rtl/serial_word_assembler.sv
// Collects a framed serial bit stream into a WIDTH-bit word and hands it to the
// downstream holding register as data_out plus a one-cycle load strobe.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any frame in progress
//   bus    serial_word_assembler_if.slave:
//            serial_in/bit_valid  serial bit and its qualifier
//            frame_start          starts (or restarts) a frame
//            data_out/load        last completed word and its strobe
//            busy                 high while collecting data (or the parity bit)
//            bit_count            data bits accepted in the current frame
//            parity_err           one-cycle pulse on a bad parity bit (PARITY_CHECK_EN)
// Build option: define PARITY_CHECK_EN to expect one even-parity bit after the
// data bits; without it the word is emitted straight after WIDTH data bits.
// All outputs are registered. load/data_out update on the edge that ends the
// EMIT cycle, so they appear one cycle after the FSM enters EMIT.
module serial_word_assembler #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_word_assembler_if.slave bus
);
    localparam int unsigned   CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StParity, StEmit} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [CntW-1:0]  bit_count_q, bit_count_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
`ifdef PARITY_CHECK_EN
    logic             parity_err_q, parity_err_d;
    logic             parity_ok;
`endif

    logic [WIDTH-1:0] sr_shifted;
    logic             last_data_bit;

    assign sr_shifted    = MSB_FIRST ? {sr_q[WIDTH-2:0], bus.serial_in}
                                     : {bus.serial_in, sr_q[WIDTH-1:1]};
    assign last_data_bit = bus.bit_valid && (bit_count_q == CntLast);
`ifdef PARITY_CHECK_EN
    // Even parity: data bits XOR parity bit must be zero.
    assign parity_ok     = ~(^sr_q ^ bus.serial_in);
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            sr_q         <= '0;
            data_out_q   <= '0;
            bit_count_q  <= '0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            data_out_q   <= data_out_d;
            bit_count_q  <= bit_count_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
`ifdef PARITY_CHECK_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.frame_start) state_d = StShift;
            end
            StShift: begin
                // frame_start wins over a bit arriving in the same cycle.
                if (!bus.frame_start && last_data_bit) begin
`ifdef PARITY_CHECK_EN
                    state_d = StParity;
`else
                    state_d = StEmit;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            StParity: begin
                if (bus.frame_start) begin
                    state_d = StShift;
                end else if (bus.bit_valid) begin
                    state_d = parity_ok ? StEmit : StIdle;
                end
            end
`endif
            StEmit: begin
                state_d = bus.frame_start ? StShift : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        sr_d         = sr_q;
        data_out_d   = data_out_q;
        bit_count_d  = bit_count_q;
        load_d       = 1'b0;
`ifdef PARITY_CHECK_EN
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.frame_start) begin
                    sr_d        = '0;
                    bit_count_d = '0;
                end
            end
            StShift: begin
                if (bus.frame_start) begin
                    sr_d        = '0;
                    bit_count_d = '0;
                end else if (bus.bit_valid) begin
                    sr_d        = sr_shifted;
                    bit_count_d = bit_count_q + CntW'(1);
                end
            end
`ifdef PARITY_CHECK_EN
            StParity: begin
                if (bus.frame_start) begin
                    sr_d        = '0;
                    bit_count_d = '0;
                end else if (bus.bit_valid && !parity_ok) begin
                    parity_err_d = 1'b1;
                    bit_count_d  = '0;
                end
            end
`endif
            StEmit: begin
                load_d      = 1'b1;
                data_out_d  = sr_q;
                bit_count_d = '0;
                if (bus.frame_start) sr_d = '0;
            end
            default: begin
                sr_d        = '0;
                bit_count_d = '0;
            end
        endcase
        busy_d = (state_d == StShift) || (state_d == StParity);
    end

    assign bus.data_out   = data_out_q;
    assign bus.load       = load_q;
    assign bus.busy       = busy_q;
    assign bus.bit_count  = bit_count_q;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err = parity_err_q;
`endif
endmodule
